// File: rtl/mmu_arbiter_pkg.sv
// Shared definitions for the MMU access arbiter: channel ids and the request bundle.
// Optional feature macro used by this slice: MMU_ARBITER_ROUND_ROBIN_EN.
package mmu_arbiter_pkg;

    localparam logic PL_ARB_CH_FETCH = 1'b0;
    localparam logic PL_ARB_CH_LSU   = 1'b1;
    localparam int   PL_ARB_CH_NUM   = 2;

    typedef struct packed {
        logic        ack_req;
        logic [1:0]  order;
        logic [3:0]  mask;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } arb_req_t;

    function automatic arb_req_t pack_req(
        input logic        ack_req,
        input logic [1:0]  order,
        input logic [3:0]  mask,
        input logic        rw,
        input logic [31:0] addr,
        input logic [31:0] data
    );
        arb_req_t r;
        r.ack_req = ack_req;
        r.order   = order;
        r.mask    = mask;
        r.rw      = rw;
        r.addr    = addr;
        r.data    = data;
        return r;
    endfunction

endpackage

// File: rtl/mmu_arbiter_route_fifo.sv
// 1-bit owner-id FIFO remembering which channel each outstanding MMU reply belongs to.
// Synchronous flush empties it; push and pop in the same cycle are legal even when full.
module mmu_arbiter_route_fifo #(
    parameter int P_DEPTH   = 16,
    parameter int P_DEPTH_N = 4
) (
    input  logic iCLOCK,
    input  logic inRESET,
    input  logic iFLUSH,
    input  logic iPUSH,
    input  logic iPUSH_ID,
    input  logic iPOP,
    output logic oFULL,
    output logic oEMPTY,
    output logic oHEAD
);

    logic [P_DEPTH-1:0]   mem_q, mem_d;
    logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_DEPTH_N:0]   count_q, count_d;
    logic                 push_ok;
    logic                 pop_ok;

    // count never exceeds the depth, so its top bit alone marks "full"
    assign oFULL  = count_q[P_DEPTH_N];
    assign oEMPTY = (count_q == '0);
    assign oHEAD  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = iPOP && !oEMPTY;
        push_ok  = iPUSH && (!oFULL || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iFLUSH) begin
            mem_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = iPUSH_ID;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmu_access_arbiter.sv
// Shares the MMU logic-request port between fetch (CH0) and load/store (CH1) and routes replies back.
// Define MMU_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed CH1 priority.
module mmu_access_arbiter
    import mmu_arbiter_pkg::*;
#(
    parameter int P_ROUTE_DEPTH   = 16,
    parameter int P_ROUTE_DEPTH_N = 4
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iCH0_REQ,
    output logic        oCH0_LOCK,
    input  logic        iCH0_ACK_REQ,
    input  logic [1:0]  iCH0_ORDER,
    input  logic [3:0]  iCH0_MASK,
    input  logic        iCH0_RW,
    input  logic [31:0] iCH0_ADDR,
    input  logic [31:0] iCH0_DATA,
    output logic        oCH0_VALID,
    output logic [63:0] oCH0_DATA,
    input  logic        iCH1_REQ,
    output logic        oCH1_LOCK,
    input  logic        iCH1_ACK_REQ,
    input  logic [1:0]  iCH1_ORDER,
    input  logic [3:0]  iCH1_MASK,
    input  logic        iCH1_RW,
    input  logic [31:0] iCH1_ADDR,
    input  logic [31:0] iCH1_DATA,
    output logic        oCH1_VALID,
    output logic [63:0] oCH1_DATA,
    output logic        oMMU_REQ,
    input  logic        iMMU_LOCK,
    output logic        oMMU_ACK_REQ,
    output logic [1:0]  oMMU_ORDER,
    output logic [3:0]  oMMU_MASK,
    output logic        oMMU_RW,
    output logic [31:0] oMMU_ADDR,
    output logic [31:0] oMMU_DATA,
    input  logic        iMMU_VALID,
    input  logic [63:0] iMMU_DATA,
    output logic        oROUTE_ERR
);

    arb_req_t ch0_req;
    arb_req_t ch1_req;
    arb_req_t sel_req;
    arb_req_t mmu_fields_q, mmu_fields_d;
    logic     mmu_req_q, mmu_req_d;
    logic     route_err_q, route_err_d;
    logic     in_reset;
    logic     stall;
    logic     prio_id;
    logic     grant_valid;
    logic     grant_id;
    logic     route_full;
    logic     route_empty;
    logic     route_head;
    logic     route_push;
    logic     reply_ok;

    assign ch0_req  = pack_req(iCH0_ACK_REQ, iCH0_ORDER, iCH0_MASK, iCH0_RW, iCH0_ADDR, iCH0_DATA);
    assign ch1_req  = pack_req(iCH1_ACK_REQ, iCH1_ORDER, iCH1_MASK, iCH1_RW, iCH1_ADDR, iCH1_DATA);
    assign in_reset = !inRESET || iRESET_SYNC;
    assign stall    = iMMU_LOCK || route_full;

`ifdef MMU_ARBITER_ROUND_ROBIN_EN
    // remembers the last granted channel; the other one has priority next
    logic rr_last_q, rr_last_d;

    always_comb begin
        rr_last_d = rr_last_q;
        if (iRESET_SYNC) begin
            rr_last_d = PL_ARB_CH_FETCH;
        end else if (grant_valid) begin
            rr_last_d = grant_id;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rr_last_q <= PL_ARB_CH_FETCH;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    assign prio_id = ~rr_last_q;
`else
    assign prio_id = PL_ARB_CH_LSU;
`endif

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = PL_ARB_CH_FETCH;
        oCH0_LOCK   = 1'b0;
        oCH1_LOCK   = 1'b0;
        if (!in_reset) begin
            if (stall) begin
                oCH0_LOCK = 1'b1;
                oCH1_LOCK = 1'b1;
            end else begin
                if (iCH0_REQ && iCH1_REQ) begin
                    grant_valid = 1'b1;
                    grant_id    = prio_id;
                end else if (iCH1_REQ) begin
                    grant_valid = 1'b1;
                    grant_id    = PL_ARB_CH_LSU;
                end else if (iCH0_REQ) begin
                    grant_valid = 1'b1;
                    grant_id    = PL_ARB_CH_FETCH;
                end
                oCH0_LOCK = iCH0_REQ && (grant_id != PL_ARB_CH_FETCH);
                oCH1_LOCK = iCH1_REQ && (grant_id != PL_ARB_CH_LSU);
            end
        end
    end

    assign sel_req    = (grant_id == PL_ARB_CH_LSU) ? ch1_req : ch0_req;
    assign route_push = grant_valid && sel_req.ack_req;

    // a stalled MMU keeps seeing the same request; otherwise REQ is a one-cycle pulse per grant
    always_comb begin
        mmu_req_d    = mmu_req_q;
        mmu_fields_d = mmu_fields_q;
        if (iRESET_SYNC) begin
            mmu_req_d    = 1'b0;
            mmu_fields_d = '0;
        end else if (grant_valid) begin
            mmu_req_d    = 1'b1;
            mmu_fields_d = sel_req;
        end else if (!iMMU_LOCK) begin
            mmu_req_d    = 1'b0;
        end
    end

    always_comb begin
        route_err_d = route_err_q;
        if (iRESET_SYNC) begin
            route_err_d = 1'b0;
        end else if (iMMU_VALID && route_empty) begin
            route_err_d = 1'b1;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            mmu_req_q    <= 1'b0;
            mmu_fields_q <= '0;
            route_err_q  <= 1'b0;
        end else begin
            mmu_req_q    <= mmu_req_d;
            mmu_fields_q <= mmu_fields_d;
            route_err_q  <= route_err_d;
        end
    end

    mmu_arbiter_route_fifo #(
        .P_DEPTH   (P_ROUTE_DEPTH),
        .P_DEPTH_N (P_ROUTE_DEPTH_N)
    ) u_route_fifo (
        .iCLOCK   (iCLOCK),
        .inRESET  (inRESET),
        .iFLUSH   (iRESET_SYNC),
        .iPUSH    (route_push),
        .iPUSH_ID (grant_id),
        .iPOP     (iMMU_VALID),
        .oFULL    (route_full),
        .oEMPTY   (route_empty),
        .oHEAD    (route_head)
    );

    assign reply_ok   = iMMU_VALID && !route_empty && !in_reset;
    assign oCH0_VALID = reply_ok && (route_head == PL_ARB_CH_FETCH);
    assign oCH1_VALID = reply_ok && (route_head == PL_ARB_CH_LSU);
    assign oCH0_DATA  = oCH0_VALID ? iMMU_DATA : 64'h0;
    assign oCH1_DATA  = oCH1_VALID ? iMMU_DATA : 64'h0;

    assign oMMU_REQ     = mmu_req_q;
    assign oMMU_ACK_REQ = mmu_fields_q.ack_req;
    assign oMMU_ORDER   = mmu_fields_q.order;
    assign oMMU_MASK    = mmu_fields_q.mask;
    assign oMMU_RW      = mmu_fields_q.rw;
    assign oMMU_ADDR    = mmu_fields_q.addr;
    assign oMMU_DATA    = mmu_fields_q.data;
    assign oROUTE_ERR   = route_err_q;

endmodule
